// File: rtl/sliding_tile_pkg.sv
// Shared definitions for the 3x3 sliding-tile puzzle:
// direction codes, reset location and move helpers.
package sliding_tile_pkg;

    localparam logic [1:0] LEFT  = 2'b00;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] UP    = 2'b10;
    localparam logic [1:0] DOWN  = 2'b11;

    localparam logic [3:0] RESET_SPACE_LOC = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        UNDO = 2'd2
    } state_t;

    function automatic logic [1:0] opposite(input logic [1:0] dir);
        return dir ^ 2'b01;
    endfunction

    function automatic logic is_legal(
        input logic [3:0] loc,
        input logic [1:0] dir
    );
        logic ok;
        ok = 1'b0;
        case (dir)
            LEFT:    ok = (loc[1:0] != 2'd0);
            RIGHT:   ok = (loc[1:0] <  2'd2);
            UP:      ok = (loc[3:2] != 2'd0);
            default: ok = (loc[3:2] <  2'd2);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] next_loc(
        input logic [3:0] loc,
        input logic [1:0] dir
    );
        logic [3:0] nl;
        nl = loc;
        case (dir)
            LEFT:    nl[1:0] = loc[1:0] - 2'd1;
            RIGHT:   nl[1:0] = loc[1:0] + 2'd1;
            UP:      nl[3:2] = loc[3:2] - 2'd1;
            default: nl[3:2] = loc[3:2] + 2'd1;
        endcase
        return nl;
    endfunction

endpackage

// File: rtl/sliding_tile_move_fifo.sv
// Small synchronous FIFO of 2-bit move directions.
// Pushes when full and pops when empty are ignored.
module sliding_tile_move_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [1:0] din,
    input  logic       pop,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty,
    output logic       last
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign last    = (count == (AW+1)'(1));
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sliding_tile_move_player.sv
// Move sequencer: buffers requested space moves, issues legal
// ones toward the puzzle, and can undo the recorded history.
module sliding_tile_move_player
    import sliding_tile_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int HIST  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [1:0] in_dir,
    input  logic       undo,
    output logic       out_val,
    output logic [1:0] out_dir,
    output logic [3:0] space_loc,
    output logic [7:0] issued_count,
    output logic [7:0] dropped_count,
    output logic       busy
);

    localparam int HW = $clog2(HIST);

    state_t state;
    state_t state_next;

    logic       fifo_pop;
    logic [1:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_last;
    logic       in_fire;

    logic [1:0]    hist_mem [HIST];
    logic [HW-1:0] hist_ptr;
    logic [HW:0]   hist_count;
    logic [1:0]    hist_top;
    logic          hist_empty;
    logic          hist_last;
    logic          hist_push;
    logic          hist_pop;

    logic       issue;
    logic [1:0] issue_dir;
    logic       drop;

    assign in_rdy     = !fifo_full;
    assign in_fire    = in_val && in_rdy;
    assign busy       = (state != IDLE);
    assign hist_top   = hist_mem[hist_ptr - 1'b1];
    assign hist_empty = (hist_count == '0);
    assign hist_last  = (hist_count == (HW+1)'(1));

    sliding_tile_move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_fire),
        .din   (in_dir),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .last  (fifo_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the per-cycle issue/drop/stack decisions.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        hist_push  = 1'b0;
        hist_pop   = 1'b0;
        issue      = 1'b0;
        issue_dir  = 2'b00;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (undo && !hist_empty) state_next = UNDO;
                else if (!fifo_empty)    state_next = PLAY;
            end
            PLAY: begin
                if (undo && !hist_empty) begin
                    state_next = UNDO;
                end else if (fifo_empty) begin
                    state_next = IDLE;
                end else begin
                    fifo_pop = 1'b1;
                    if (is_legal(space_loc, fifo_dout)) begin
                        issue     = 1'b1;
                        issue_dir = fifo_dout;
                        hist_push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    if (fifo_last && !in_fire) state_next = IDLE;
                end
            end
            UNDO: begin
                if (hist_empty) begin
                    state_next = fifo_empty ? IDLE : PLAY;
                end else begin
                    hist_pop  = 1'b1;
                    issue     = 1'b1;
                    issue_dir = opposite(hist_top);
                    if (hist_last) begin
                        state_next = (!fifo_empty || in_fire) ? PLAY : IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // History storage; a push when full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (hist_push) begin
            hist_mem[hist_ptr] <= issue_dir;
        end
    end

    // Registered outputs, space mirror, counters and stack pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val       <= 1'b0;
            out_dir       <= 2'b00;
            space_loc     <= RESET_SPACE_LOC;
            issued_count  <= 8'd0;
            dropped_count <= 8'd0;
            hist_ptr      <= '0;
            hist_count    <= '0;
        end else begin
            out_val <= issue;
            out_dir <= issue_dir;
            if (issue) begin
                space_loc <= next_loc(space_loc, issue_dir);
                if (issued_count != 8'hFF)
                    issued_count <= issued_count + 8'd1;
            end
            if (drop && dropped_count != 8'hFF)
                dropped_count <= dropped_count + 8'd1;
            if (hist_push) begin
                hist_ptr <= hist_ptr + 1'b1;
                if (hist_count != (HW+1)'(HIST))
                    hist_count <= hist_count + 1'b1;
            end else if (hist_pop) begin
                hist_ptr   <= hist_ptr - 1'b1;
                hist_count <= hist_count - 1'b1;
            end
        end
    end

endmodule
